wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Purpose : shares the register-file write port between pipeline WB and a multi-cycle unit,
//           queuing multi-cycle results and tracking their destinations for hazard stalls.
// Latency : pipeline writes appear 1 edge after WB; queued results pop no earlier than 1 edge after accept.
// Backpr. : mc_ready=0 while the FIFO is full; pipe_hold asks the pipeline for a bubble.
// Ports   : clk/reset; RegWrite/write_reg/write_back_data (pipeline WB in);
//           mc_valid/mc_write_reg/mc_write_data/mc_ready (multi-cycle result in);
//           issue_valid/issue_dest (scoreboard set); rs/rt/mc_busy_stall (hazard query);
//           pipe_hold; RegWrite_out/write_reg_out/write_back_data_out (registered RF write port).
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_back_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_write_reg,
    input  logic [31:0] mc_write_data,
    output logic        mc_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dest,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        mc_busy_stall,
    output logic        pipe_hold,
    output logic        RegWrite_out,
    output logic [4:0]  write_reg_out,
    output logic [31:0] write_back_data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [4:0]    fifo_dest [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   busy;
    logic [31:0]   busy_nxt;
    logic [CW-1:0] starve_cnt;

    logic          empty;
    logic          full;
    logic          pipe_win;
    logic          pop;
    logic          push;
    logic          accept;
    logic [4:0]    head_dest;
    logic [31:0]   head_data;

    assign empty     = (wr_ptr == rd_ptr);
    // Extra MSB distinguishes full from empty when the index bits match.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign mc_ready  = !full;
    assign pipe_win  = RegWrite && (write_reg != 5'd0);
    assign pop       = !pipe_win && !empty;
    assign accept    = mc_valid && !full;
    // r0 results are handshaken but never stored.
    assign push      = accept && (mc_write_reg != 5'd0);
    assign head_dest = fifo_dest[rd_ptr[AW-1:0]];
    assign head_data = fifo_data[rd_ptr[AW-1:0]];

    assign mc_busy_stall = busy[rs] | busy[rt];
    assign pipe_hold     = full || (starve_cnt == LIMIT);

    // Set is applied after clear so a same-cycle reissue of the popped dest stays pending.
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[head_dest] = 1'b0;
        end
        if (issue_valid) begin
            busy_nxt[issue_dest] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest[wr_ptr[AW-1:0]] <= mc_write_reg;
            fifo_data[wr_ptr[AW-1:0]] <= mc_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            busy                <= '0;
            starve_cnt          <= '0;
            RegWrite_out        <= 1'b0;
            write_reg_out       <= 5'd0;
            write_back_data_out <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            busy <= busy_nxt;

            if (pop || empty) begin
                starve_cnt <= '0;
            end else if (pipe_win && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + CW'(1);
            end

            // Address/data hold their last value on idle cycles.
            if (pipe_win) begin
                RegWrite_out        <= 1'b1;
                write_reg_out       <= write_reg;
                write_back_data_out <= write_back_data;
            end else if (pop) begin
                RegWrite_out        <= 1'b1;
                write_reg_out       <= head_dest;
                write_back_data_out <= head_data;
            end else begin
                RegWrite_out        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWrite = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_back_data = '0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_write_reg = '0;
    logic [31:0] mc_write_data = '0;
    logic        mc_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic        mc_busy_stall;
    logic        pipe_hold;
    logic        RegWrite_out;
    logic [4:0]  write_reg_out;
    logic [31:0] write_back_data_out;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_back_data(write_back_data),
        .mc_valid(mc_valid), .mc_write_reg(mc_write_reg), .mc_write_data(mc_write_data),
        .mc_ready(mc_ready),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .rs(rs), .rt(rt), .mc_busy_stall(mc_busy_stall), .pipe_hold(pipe_hold),
        .RegWrite_out(RegWrite_out), .write_reg_out(write_reg_out),
        .write_back_data_out(write_back_data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending results as a plain queue, pending dests as a bit set.
    logic [4:0]  m_dest[$];
    logic [31:0] m_data[$];
    bit          m_busy[32];
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_wd;

    // Expected registered outputs {we, reg, data}, one per clock edge.
    logic [37:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: after every edge, compare the write port against the next expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [37:0] e;
            e = exp_q.pop_front();
            check("RegWrite_out", {31'd0, RegWrite_out}, {31'd0, e[37]});
            check("write_reg_out", {27'd0, write_reg_out}, {27'd0, e[36:32]});
            check("write_back_data_out", write_back_data_out, e[31:0]);
        end
    end

    task automatic model_reset();
        m_dest.delete();
        m_data.delete();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_starve = 0;
        m_we = 1'b0;
        m_reg = '0;
        m_wd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        RegWrite = 1'b0; mc_valid = 1'b0; issue_valid = 1'b0;
        model_reset();
        exp_q.push_back({m_we, m_reg, m_wd});
    endtask

    task automatic cycle(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic iv, input logic [4:0] id,
                         input logic [4:0] qs, input logic [4:0] qt);
        bit full, pw, popped;
        @(negedge clk);
        reset = 1'b0;
        RegWrite = rw; write_reg = wr; write_back_data = wd;
        mc_valid = mv; mc_write_reg = mr; mc_write_data = md;
        issue_valid = iv; issue_dest = id; rs = qs; rt = qt;
        #1;
        full = (m_dest.size() == DEPTH);
        check("mc_ready", {31'd0, mc_ready}, {31'd0, !full});
        check("pipe_hold", {31'd0, pipe_hold}, {31'd0, full || (m_starve == STARVE_LIMIT)});
        check("mc_busy_stall", {31'd0, mc_busy_stall}, {31'd0, m_busy[qs] || m_busy[qt]});

        pw = rw && (wr != 0);
        popped = !pw && (m_dest.size() > 0);
        if (popped || m_dest.size() == 0) m_starve = 0;
        else if (m_starve < STARVE_LIMIT) m_starve++;
        if (pw) begin
            m_we = 1'b1; m_reg = wr; m_wd = wd;
        end else if (popped) begin
            m_we = 1'b1; m_reg = m_dest.pop_front(); m_wd = m_data.pop_front();
            m_busy[m_reg] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (mv && !full && mr != 0) begin
            m_dest.push_back(mr);
            m_data.push_back(md);
        end
        if (iv && id != 0) m_busy[id] = 1'b1;
        exp_q.push_back({m_we, m_reg, m_wd});
    endtask

    task automatic idle(input int n, input logic [4:0] q);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, q, q);
    endtask

    initial begin
        do_reset();
        idle(2, 5'd0);

        // Reset discards queued results while the pipeline keeps the port busy.
        cycle(1, 3, 32'h33, 1, 5, 32'h11, 1, 5, 5, 6);
        cycle(1, 3, 32'h34, 1, 6, 32'h22, 1, 6, 5, 6);
        cycle(1, 3, 32'h35, 0, 0, 0, 0, 0, 5, 6);
        do_reset();
        idle(4, 5'd5);

        // Idle port: result written two edges after accept, stall clears at the pop edge.
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        cycle(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0);
        idle(3, 5'd7);

        // Contention: pipeline keeps winning until starve limit, then one bubble drains r10.
        cycle(1, 9, 32'h900, 1, 10, 32'h1, 1, 10, 10, 9);
        for (int i = 1; i < 6; i++) cycle(1, 9, 32'h900 + i, 0, 0, 0, 0, 0, 10, 9);
        idle(2, 5'd10);

        // Full FIFO: third push is refused, r1 drains first.
        cycle(1, 9, 32'h1, 1, 1, 32'hA, 0, 0, 1, 2);
        cycle(1, 9, 32'h2, 1, 2, 32'hB, 0, 0, 1, 2);
        cycle(1, 9, 32'h3, 1, 3, 32'hC, 0, 0, 1, 2);
        idle(4, 5'd3);

        // r0 handling.
        cycle(1, 9, 32'h4, 1, 4, 32'h44, 1, 4, 4, 0);
        cycle(1, 0, 32'hBAD, 0, 0, 0, 0, 0, 4, 0);
        cycle(0, 0, 0, 1, 0, 32'hBAD0, 1, 0, 0, 4);
        idle(3, 5'd0);

        // Set/clear collision on r8.
        cycle(1, 9, 32'h8, 1, 8, 32'h88, 1, 8, 8, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 8, 8, 0);
        idle(2, 5'd8);
        cycle(0, 0, 0, 1, 8, 32'h89, 0, 0, 8, 8);
        idle(3, 5'd8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                      $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
                      $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
        end
        idle(6, 5'd0);

        @(negedge clk);
        check("expectations drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
